// File: rtl/alignment_ignition_gate.sv
// Turns smoothed detector sensitivity plus an SR request into one shaped ignition episode:
// arm after a sustained dwell, then ramp gain up, hold, ramp down and sit out a refractory period.
module alignment_ignition_gate #(
  parameter int WIDTH          = 18,
  parameter int FRAC           = 14,
  parameter int EMA_SHIFT      = 4,
  parameter int ARM_THRESH     = 9830,
  parameter int DISARM_THRESH  = 8192,
  parameter int DWELL_CYCLES   = 16,
  parameter int RAMP_STEP      = 1024,
  parameter int HOLD_CYCLES    = 32,
  parameter int REFRACT_CYCLES = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clk_en,
  input  logic signed [WIDTH-1:0]     ignition_sensitivity,
  input  logic                        sr_event,
  output logic signed [WIDTH-1:0]     sens_smoothed,
  output logic        [2:0]           state,
  output logic                        ignition_active,
  output logic                        ignition_pulse,
  output logic signed [WIDTH-1:0]     ignition_gain,
  output logic        [CNT_WIDTH-1:0] event_count,
  output logic        [CNT_WIDTH-1:0] missed_count
);

  localparam int OneInt = 1 << FRAC;
  localparam int DwellW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int HoldW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int RefW   = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;

  localparam logic signed [WIDTH-1:0] One       = WIDTH'(OneInt);
  localparam logic signed [WIDTH:0]   OneX      = (WIDTH+1)'(OneInt);
  localparam logic signed [WIDTH:0]   StepX     = (WIDTH+1)'(RAMP_STEP);
  localparam logic signed [WIDTH-1:0] ArmThr    = WIDTH'(ARM_THRESH);
  localparam logic signed [WIDTH-1:0] DisarmThr = WIDTH'(DISARM_THRESH);
  localparam logic [DwellW-1:0]       DwellLast = DwellW'(DWELL_CYCLES - 1);
  localparam logic [HoldW-1:0]        HoldLast  = HoldW'(HOLD_CYCLES - 1);
  localparam logic [RefW-1:0]         RefLast   = RefW'(REFRACT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StArmed   = 3'd1,
    StRise    = 3'd2,
    StHold    = 3'd3,
    StFall    = 3'd4,
    StRefract = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic signed [WIDTH-1:0]   sens_q, sens_d;
  logic signed [WIDTH-1:0]   gain_q, gain_d;
  logic [DwellW-1:0]         dwell_q, dwell_d;
  logic [HoldW-1:0]          hold_q, hold_d;
  logic [RefW-1:0]           ref_q, ref_d;
  logic [CNT_WIDTH-1:0]      event_q, event_d;
  logic [CNT_WIDTH-1:0]      missed_q, missed_d;
  logic                      pulse_q, pulse_d;

  logic signed [WIDTH-1:0]   x_clamp;
  logic signed [WIDTH:0]     ema_diff, ema_step;
  logic signed [WIDTH-1:0]   sens_next;
  logic signed [WIDTH:0]     gain_ext, gain_up, gain_dn;
  logic                      unused_ema_msb;

  // Clamp then EMA; the difference carries one guard bit so it cannot wrap.
  always_comb begin
    if (ignition_sensitivity < 0) begin
      x_clamp = '0;
    end else if (ignition_sensitivity > One) begin
      x_clamp = One;
    end else begin
      x_clamp = ignition_sensitivity;
    end
    ema_diff  = {x_clamp[WIDTH-1], x_clamp} - {sens_q[WIDTH-1], sens_q};
    ema_step  = ema_diff >>> EMA_SHIFT;
    sens_next = sens_q + ema_step[WIDTH-1:0];
  end

  assign unused_ema_msb = ema_step[WIDTH];

  always_comb begin
    gain_ext = {gain_q[WIDTH-1], gain_q};
    gain_up  = gain_ext + StepX;
    gain_dn  = gain_ext - StepX;
  end

  always_comb begin
    state_d  = state_q;
    sens_d   = sens_q;
    gain_d   = gain_q;
    dwell_d  = dwell_q;
    hold_d   = hold_q;
    ref_d    = ref_q;
    event_d  = event_q;
    missed_d = missed_q;
    pulse_d  = 1'b0;

    if (clk_en) begin
      sens_d = sens_next;

      if (sr_event && (state_q != StArmed) && (missed_q != '1)) begin
        missed_d = missed_q + CNT_WIDTH'(1);
      end

      case (state_q)
        StIdle: begin
          if (sens_q >= ArmThr) begin
            if (dwell_q == DwellLast) begin
              state_d = StArmed;
              dwell_d = '0;
            end else begin
              dwell_d = dwell_q + DwellW'(1);
            end
          end else begin
            dwell_d = '0;
          end
        end
        StArmed: begin
          // A request wins over disarm on the same edge.
          if (sr_event) begin
            state_d = StRise;
            pulse_d = 1'b1;
            if (event_q != '1) begin
              event_d = event_q + CNT_WIDTH'(1);
            end
          end else if (sens_q < DisarmThr) begin
            state_d = StIdle;
          end
        end
        StRise: begin
          if (gain_up >= OneX) begin
            gain_d  = One;
            state_d = StHold;
          end else begin
            gain_d = gain_up[WIDTH-1:0];
          end
        end
        StHold: begin
          if (hold_q == HoldLast) begin
            hold_d  = '0;
            state_d = StFall;
          end else begin
            hold_d = hold_q + HoldW'(1);
          end
        end
        StFall: begin
          if (gain_dn[WIDTH] || (gain_dn == '0)) begin
            gain_d  = '0;
            state_d = StRefract;
          end else begin
            gain_d = gain_dn[WIDTH-1:0];
          end
        end
        StRefract: begin
          if (ref_q == RefLast) begin
            ref_d   = '0;
            dwell_d = '0;
            state_d = StIdle;
          end else begin
            ref_d = ref_q + RefW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          gain_d  = '0;
          dwell_d = '0;
          hold_d  = '0;
          ref_d   = '0;
        end
      endcase
    end
  end

  // The pulse register is not gated by clk_en so it stays exactly one clk wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sens_q   <= '0;
      gain_q   <= '0;
      dwell_q  <= '0;
      hold_q   <= '0;
      ref_q    <= '0;
      event_q  <= '0;
      missed_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sens_q   <= sens_d;
      gain_q   <= gain_d;
      dwell_q  <= dwell_d;
      hold_q   <= hold_d;
      ref_q    <= ref_d;
      event_q  <= event_d;
      missed_q <= missed_d;
      pulse_q  <= pulse_d;
    end
  end

  assign sens_smoothed   = sens_q;
  assign state           = state_q;
  assign ignition_active = (state_q == StRise) || (state_q == StHold) || (state_q == StFall);
  assign ignition_pulse  = pulse_q;
  assign ignition_gain   = gain_q;
  assign event_count     = event_q;
  assign missed_count    = missed_q;

endmodule

// File: tb/tb_alignment_ignition_gate.sv
// Scoreboard bench: a behavioural model queues expected outputs per clk, compared after the edge.
// A second instance with 2-bit counters exercises counter saturation.
module tb_alignment_ignition_gate;

  logic               clk;
  logic               rst_n;
  logic               clk_en;
  logic signed [17:0] ignition_sensitivity;
  logic               sr_event;

  logic signed [17:0] sens_smoothed, ignition_gain;
  logic [2:0]         state;
  logic               ignition_active, ignition_pulse;
  logic [15:0]        event_count, missed_count;

  logic signed [17:0] s_sens, s_gain;
  logic [2:0]         s_state;
  logic               s_active, s_pulse;
  logic [1:0]         s_ev, s_miss;

  alignment_ignition_gate u_dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .clk_en               (clk_en),
    .ignition_sensitivity (ignition_sensitivity),
    .sr_event             (sr_event),
    .sens_smoothed        (sens_smoothed),
    .state                (state),
    .ignition_active      (ignition_active),
    .ignition_pulse       (ignition_pulse),
    .ignition_gain        (ignition_gain),
    .event_count          (event_count),
    .missed_count         (missed_count)
  );

  alignment_ignition_gate #(.CNT_WIDTH(2)) u_small (
    .clk                  (clk),
    .rst_n                (rst_n),
    .clk_en               (clk_en),
    .ignition_sensitivity (ignition_sensitivity),
    .sr_event             (sr_event),
    .sens_smoothed        (s_sens),
    .state                (s_state),
    .ignition_active      (s_active),
    .ignition_pulse       (s_pulse),
    .ignition_gain        (s_gain),
    .event_count          (s_ev),
    .missed_count         (s_miss)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int sens;
    int st;
    bit act;
    bit pul;
    int gain;
    int ev;
    int miss;
    int ev2;
    int miss2;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  int m_s, m_state, m_dwell, m_hold, m_ref, m_gain, m_ev, m_miss, m_ev2, m_miss2;
  bit m_pulse;
  bit duty4 = 1'b0;
  int cyc = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s = 0; m_state = 0; m_dwell = 0; m_hold = 0; m_ref = 0; m_gain = 0;
    m_ev = 0; m_miss = 0; m_ev2 = 0; m_miss2 = 0; m_pulse = 1'b0;
  endtask

  task automatic model_step();
    int x;
    int s_n;
    m_pulse = 1'b0;
    if (!clk_en) return;
    x = int'(ignition_sensitivity);
    if (x < 0) x = 0;
    if (x > 16384) x = 16384;
    s_n = m_s + ((x - m_s) >>> 4);
    if (sr_event && m_state != 1) begin
      if (m_miss < 65535) m_miss++;
      if (m_miss2 < 3) m_miss2++;
    end
    case (m_state)
      0: begin
        if (m_s >= 9830) begin
          if (m_dwell == 15) begin m_state = 1; m_dwell = 0; end
          else m_dwell++;
        end else m_dwell = 0;
      end
      1: begin
        if (sr_event) begin
          m_state = 2; m_pulse = 1'b1;
          if (m_ev < 65535) m_ev++;
          if (m_ev2 < 3) m_ev2++;
        end else if (m_s < 8192) m_state = 0;
      end
      2: begin
        m_gain = m_gain + 1024;
        if (m_gain >= 16384) begin m_gain = 16384; m_state = 3; end
      end
      3: begin
        if (m_hold == 31) begin m_hold = 0; m_state = 4; end
        else m_hold++;
      end
      4: begin
        m_gain = m_gain - 1024;
        if (m_gain <= 0) begin m_gain = 0; m_state = 5; end
      end
      5: begin
        if (m_ref == 63) begin m_ref = 0; m_dwell = 0; m_state = 0; end
        else m_ref++;
      end
      default: m_state = 0;
    endcase
    m_s = s_n;
  endtask

  task automatic tick();
    exp_t e;
    if (duty4) clk_en = (cyc % 4 == 0);
    cyc++;
    model_step();
    e = '{m_s, m_state, (m_state >= 2 && m_state <= 4), m_pulse, m_gain, m_ev, m_miss, m_ev2,
          m_miss2};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sens", sens_smoothed, e.sens);
    check("state", state, e.st);
    check("active", ignition_active, e.act);
    check("pulse", ignition_pulse, e.pul);
    check("gain", ignition_gain, e.gain);
    check("event_count", event_count, e.ev);
    check("missed_count", missed_count, e.miss);
    check("small_state", s_state, e.st);
    check("small_gain", s_gain, e.gain);
    check("small_event", s_ev, e.ev2);
    check("small_missed", s_miss, e.miss2);
  endtask

  task automatic run_until(input int st, input int maxn, input string tag, output int n);
    n = 0;
    while (int'(state) != st && n < maxn) begin
      tick();
      n++;
    end
    check(tag, state, st);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_sens"}, sens_smoothed, 0);
    check({tag, "_gain"}, ignition_gain, 0);
    check({tag, "_event"}, event_count, 0);
    check({tag, "_missed"}, missed_count, 0);
    check({tag, "_pulse"}, ignition_pulse, 0);
    check({tag, "_active"}, ignition_active, 0);
  endtask

  initial begin
    int n;
    int first;
    int pw;
    int prev;

    rst_n = 1'b0;
    clk_en = 1'b0;
    sr_event = 1'b0;
    ignition_sensitivity = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Step arm from zero
    clk_en = 1'b1;
    ignition_sensitivity = 18'sd16384;
    tick();
    check("ema_first", sens_smoothed, 1024);
    tick();
    check("ema_second", sens_smoothed, 1984);
    first = -1;
    n = 0;
    while (state != 3'd1 && n < 200) begin
      tick();
      if (first < 0 && sens_smoothed >= 9830) first = n;
      n++;
    end
    check("arm_latency", (n - 1) - first, 16);

    // Input drops: disarm on first edge with s < 8192
    ignition_sensitivity = '0;
    run_until(0, 200, "disarm", n);

    // Full episode with missed requests in RISE and REFRACT
    ignition_sensitivity = 18'sd16384;
    run_until(1, 200, "rearm", n);
    sr_event = 1'b1;
    tick();
    sr_event = 1'b0;
    check("ign_pulse", ignition_pulse, 1);
    check("ign_state", state, 2);
    check("ign_gain0", ignition_gain, 0);
    n = 0;
    while (state != 3'd0 && n < 300) begin
      sr_event = (n == 2) || (n == 99);
      tick();
      n++;
    end
    sr_event = 1'b0;
    check("episode_len", n, 128);
    check("episode_events", event_count, 1);
    sr_event = 1'b1;
    tick();
    check("missed_three", missed_count, 3);
    check("small_missed_three", s_miss, 3);
    tick();
    sr_event = 1'b0;
    check("missed_four", missed_count, 4);
    check("small_missed_sat", s_miss, 3);
    check("events_unchanged", event_count, 1);

    // Simultaneous disarm condition and request: request wins
    run_until(1, 200, "arm_sim", n);
    ignition_sensitivity = '0;
    n = 0;
    while (sens_smoothed >= 8192 && n < 100) begin
      tick();
      n++;
    end
    check("still_armed", state, 1);
    sr_event = 1'b1;
    tick();
    sr_event = 1'b0;
    check("sim_rise", state, 2);
    ignition_sensitivity = -18'sd5000;
    prev = int'(sens_smoothed);
    tick();
    check("neg_decay", (int'(sens_smoothed) < prev) && (sens_smoothed >= 0), 1);
    run_until(0, 300, "sim_episode_end", n);
    check("sim_events", event_count, 2);

    // Enable duty 1/4
    duty4 = 1'b1;
    ignition_sensitivity = 18'sd16384;
    run_until(1, 800, "duty_arm", n);
    sr_event = 1'b1;
    n = 0;
    while (state != 3'd2 && n < 20) begin
      tick();
      n++;
    end
    sr_event = 1'b0;
    check("duty_rise", state, 2);
    pw = ignition_pulse ? 1 : 0;
    n = 0;
    while (state != 3'd0 && n < 1000) begin
      tick();
      n++;
      if (ignition_pulse) pw++;
    end
    check("duty_episode_clks", n, 512);
    check("duty_pulse_width", pw, 1);
    check("duty_events", event_count, 3);
    duty4 = 1'b0;
    clk_en = 1'b1;

    // Fourth episode saturates the narrow event counter
    run_until(1, 200, "arm4", n);
    sr_event = 1'b1;
    tick();
    sr_event = 1'b0;
    run_until(0, 300, "episode4_end", n);
    check("events_four", event_count, 4);
    check("small_events_sat", s_ev, 3);

    // Asynchronous reset in the middle of HOLD
    run_until(1, 200, "arm5", n);
    sr_event = 1'b1;
    tick();
    sr_event = 1'b0;
    run_until(3, 100, "reach_hold", n);
    repeat (5) tick();
    rst_n = 1'b0;
    #2;
    check_reset_outputs("mid_hold");
    model_reset();
    #2;
    rst_n = 1'b1;
    ignition_sensitivity = '0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
